dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared single-port data memory. It accepts load/store requests from the CPU load/store unit (port 0) and the debug/DMA loader (port 1). Each cycle it grants at most one request and drives the memory's address, write-enable, write-data and byte-enable inputs. It also registers the memory's asynchronous read data back to the winning requester. It sits between the requesters and the data memory in the top-level integration.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory: round-robin with lock.
// Optional starvation guard on locks is enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    input  logic              req0_we_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [3:0]        req0_be_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic              req0_lock_i,
    output logic              req0_ready_o,
    output logic              req0_rvalid_o,
    output logic [DATA_W-1:0] req0_rdata_o,
    input  logic              req1_valid_i,
    input  logic              req1_we_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [3:0]        req1_be_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic              req1_lock_i,
    output logic              req1_ready_o,
    output logic              req1_rvalid_o,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_en_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic [3:0]        mem_byte_en_o,
    input  logic [DATA_W-1:0] mem_rd_data_i
);
    typedef enum logic [1:0] {LK_NONE = 2'd0, LK_P0 = 2'd1, LK_P1 = 2'd2} lock_e;

    logic [1:0]             valid, we, lock;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0][3:0]        be;

    assign valid = {req1_valid_i, req0_valid_i};
    assign we    = {req1_we_i, req0_we_i};
    assign lock  = {req1_lock_i, req0_lock_i};
    assign addr  = {req1_addr_i, req0_addr_i};
    assign wdata = {req1_wdata_i, req0_wdata_i};
    assign be    = {req1_be_i, req0_be_i};

    logic                   last_gnt_q, last_gnt_d;
    lock_e                  lock_own_q, lock_own_d;
    logic [1:0]             rvalid_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    logic own_idx, lock_hold, lock_denied, lock_ovr;
    logic gnt_any, gnt_idx, be_legal;

    assign own_idx     = (lock_own_q == LK_P1);
    assign lock_hold   = (lock_own_q != LK_NONE) && valid[own_idx];
    assign lock_denied = lock_hold && valid[~own_idx];

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Once the non-owner has waited STARVE_MAX locked cycles, it wins and the lock is broken.
    assign lock_ovr     = lock_denied && (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign starve_cnt_d = (lock_denied && !lock_ovr) ? starve_cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    assign lock_ovr = 1'b0;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (lock_ovr) begin
            gnt_any = 1'b1;
            gnt_idx = ~own_idx;
        end else if (lock_hold) begin
            gnt_any = 1'b1;
            gnt_idx = own_idx;
        end else if (valid[0] && valid[1]) begin
            gnt_any = 1'b1;
            gnt_idx = ~last_gnt_q;
        end else if (valid[0]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b0;
        end else if (valid[1]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b1;
        end
    end

    assign be_legal = (be[gnt_idx] == 4'b0001) || (be[gnt_idx] == 4'b0011) ||
                      (be[gnt_idx] == 4'b1111);

    assign req0_ready_o = gnt_any && !gnt_idx;
    assign req1_ready_o = gnt_any && gnt_idx;

    // Illegal byte enables still get a grant, but the store never reaches the array.
    assign mem_addr_o    = gnt_any ? addr[gnt_idx]  : '0;
    assign mem_wr_data_o = gnt_any ? wdata[gnt_idx] : '0;
    assign mem_byte_en_o = gnt_any ? be[gnt_idx]    : 4'b0000;
    assign mem_wr_en_o   = gnt_any && we[gnt_idx] && be_legal;

    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_own_d = LK_NONE;
        if (gnt_any) begin
            last_gnt_d = gnt_idx;
            if (lock[gnt_idx] && !lock_ovr) lock_own_d = gnt_idx ? LK_P1 : LK_P0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            lock_own_q <= LK_NONE;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_own_q <= lock_own_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rvalid_q[p] <= gnt_any && (gnt_idx == 1'(p)) && !we[p];
                if (gnt_any && (gnt_idx == 1'(p)) && !we[p]) rdata_q[p] <= mem_rd_data_i;
            end
        end
    end

    assign req0_rvalid_o = rvalid_q[0];
    assign req1_rvalid_o = rvalid_q[1];
    assign req0_rdata_o  = rdata_q[0];
    assign req1_rdata_o  = rdata_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (winner choice, memory image, load responses).
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v[2], we[2], lk[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [3:0]    be[2];
    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wd, m_rdat;
    logic [3:0]    m_be;

    logic [DW-1:0] env_mem[256];
    logic [DW-1:0] ref_mem[256];
    int            nchk = 0;
    int            npass = 0;

    // reference model state
    int            m_last, m_owner, m_starve;
    bit            m_rv[2];
    logic [DW-1:0] m_rd[2];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(v[0]), .req0_we_i(we[0]), .req0_addr_i(ad[0]), .req0_be_i(be[0]),
        .req0_wdata_i(wd[0]), .req0_lock_i(lk[0]), .req0_ready_o(rdy0),
        .req0_rvalid_o(rv0), .req0_rdata_o(rd0),
        .req1_valid_i(v[1]), .req1_we_i(we[1]), .req1_addr_i(ad[1]), .req1_be_i(be[1]),
        .req1_wdata_i(wd[1]), .req1_lock_i(lk[1]), .req1_ready_o(rdy1),
        .req1_rvalid_o(rv1), .req1_rdata_o(rd1),
        .mem_addr_o(m_addr), .mem_wr_en_o(m_we), .mem_wr_data_o(m_wd),
        .mem_byte_en_o(m_be), .mem_rd_data_i(m_rdat)
    );

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b = i[7:0];
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] e);
        logic [31:0] r = o;
        for (int k = 0; k < 4; k++) if (e[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic bit legal(logic [3:0] e);
        return (e == 4'b0001) || (e == 4'b0011) || (e == 4'b1111);
    endfunction

    // memory behind the arbiter: async read, byte-masked write at the edge
    assign m_rdat = env_mem[m_addr[7:0]];
    always @(posedge clk) if (m_we) env_mem[m_addr[7:0]] <= merge(env_mem[m_addr[7:0]], m_wd, m_be);

    function automatic int pick(output bit ovr);
        ovr = 1'b0;
        if (m_owner >= 0 && v[m_owner]) begin
`ifdef DMEM_ARB_STARVE_GUARD_EN
            if (v[1-m_owner] && m_starve == SMAX) begin
                ovr = 1'b1;
                return 1 - m_owner;
            end
`endif
            return m_owner;
        end
        if (v[0] && v[1]) return 1 - m_last;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 1; m_owner = -1; m_starve = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    task automatic model_adv();
        bit ovr;
        int w;
        w = pick(ovr);
        m_starve = (m_owner >= 0 && v[m_owner] && v[1-m_owner] && !ovr) ? m_starve + 1 : 0;
        m_rv[0] = 0; m_rv[1] = 0;
        if (w >= 0) begin
            if (we[w]) begin
                if (legal(be[w])) ref_mem[ad[w][7:0]] = merge(ref_mem[ad[w][7:0]], wd[w], be[w]);
            end else begin
                m_rv[w] = 1;
                m_rd[w] = ref_mem[ad[w][7:0]];
            end
            m_last  = w;
            m_owner = (lk[w] && !ovr) ? w : -1;
        end else begin
            m_owner = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_adv();
        #1;
    endtask

    task automatic drive(int p, logic val, logic w, logic [AW-1:0] a, logic [3:0] e,
                         logic [DW-1:0] d, logic l);
        v[p] = val; we[p] = w; ad[p] = a; be[p] = e; wd[p] = d; lk[p] = l;
    endtask

    task automatic idle_all();
        drive(0, 0, 0, '0, 4'b0000, '0, 0);
        drive(1, 0, 0, '0, 4'b0000, '0, 0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        model_reset();
        tick();
        #2;
        nchk++;
        if ({rdy1, rdy0, rv1, rv0} !== 4'b0000)
            $display("FAIL reset_flags got %b exp 0000", {rdy1, rdy0, rv1, rv0});
        else npass++;
        nchk++;
        if ({rd1, rd0} !== 64'h0) $display("FAIL reset_rdata got %h exp 0", {rd1, rd0});
        else npass++;
        nchk++;
        if ({m_addr, m_we, m_wd, m_be} !== '0)
            $display("FAIL reset_mem got %h exp 0", {m_addr, m_we, m_wd, m_be});
        else npass++;
        rst = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        drive(0, 1, 0, 32'h20, 4'b1111, '0, 0);
        drive(1, 1, 0, 32'h21, 4'b1111, '0, 0);
        #2;
        nchk++;
        if ({rdy1, rdy0, m_addr} !== {2'b01, 32'h20})
            $display("FAIL tie_c1 got %b/%h exp 01/20", {rdy1, rdy0}, m_addr);
        else npass++;
        tick();
        v[0] = 0;
        #2;
        nchk++;
        if ({rdy1, rdy0, m_addr} !== {2'b10, 32'h21})
            $display("FAIL tie_c2 got %b/%h exp 10/21", {rdy1, rdy0}, m_addr);
        else npass++;
        nchk++;
        if ({rv0, rd0} !== {1'b1, init_word(32'h20)})
            $display("FAIL tie_rv0 got %b/%h exp 1/%h", rv0, rd0, init_word(32'h20));
        else npass++;
        tick();
        v[1] = 0;
        #2;
        nchk++;
        if ({rv1, rv0, rd1} !== {2'b10, init_word(32'h21)})
            $display("FAIL tie_rv1 got %b/%h exp 10/%h", {rv1, rv0}, rd1, init_word(32'h21));
        else npass++;
        tick();
    endtask

    task automatic test_store_load();
        do_reset();
        drive(0, 1, 1, 32'h10004, 4'b1111, 32'hCAFEF00D, 0);
        #2;
        nchk++;
        if ({rdy0, m_we, m_addr, m_wd, m_be} !== {2'b11, 32'h10004, 32'hCAFEF00D, 4'b1111})
            $display("FAIL store_mem got %b%b %h %h %b", rdy0, m_we, m_addr, m_wd, m_be);
        else npass++;
        tick();
        drive(0, 1, 0, 32'h10004, 4'b1111, '0, 0);
        #2;
        nchk++;
        if ({rdy0, m_we} !== 2'b10) $display("FAIL load_gnt got %b exp 10", {rdy0, m_we});
        else npass++;
        tick();
        v[0] = 0;
        #2;
        nchk++;
        if ({rv0, rd0} !== {1'b1, 32'hCAFEF00D})
            $display("FAIL store_load got %b/%h exp 1/cafef00d", rv0, rd0);
        else npass++;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        drive(0, 1, 0, 32'h40, 4'b1111, '0, 0);
        drive(1, 1, 0, 32'h41, 4'b1111, '0, 0);
        for (int c = 0; c < 6; c++) begin
            #2;
            nchk++;
            if ({rdy1, rdy0} !== ((c % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_c%0d got %b exp %0d", c, {rdy1, rdy0}, c % 2);
            else npass++;
            tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        drive(1, 1, 0, 32'h50, 4'b1111, '0, 1);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) drive(0, 1, 0, 32'h51, 4'b1111, '0, 0);
            #2;
            nchk++;
            if ({rdy1, rdy0} !== 2'b10) $display("FAIL lock_beat%0d got %b exp 10", c, {rdy1, rdy0});
            else npass++;
            tick();
        end
        v[1] = 0;
        #2;
        nchk++;
        if ({rdy1, rdy0} !== 2'b01) $display("FAIL lock_release got %b exp 01", {rdy1, rdy0});
        else npass++;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_starve();
        logic [1:0] exp_seq[5];
`ifdef DMEM_ARB_STARVE_GUARD_EN
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        do_reset();
        drive(1, 1, 0, 32'h60, 4'b1111, '0, 1);
        tick();
        drive(0, 1, 0, 32'h61, 4'b1111, '0, 0);
        for (int c = 0; c < 5; c++) begin
            #2;
            nchk++;
            if ({rdy1, rdy0} !== exp_seq[c])
                $display("FAIL starve_c%0d got %b exp %b", c, {rdy1, rdy0}, exp_seq[c]);
            else npass++;
            if (rdy0) begin
                tick();
                v[0] = 0;
            end else tick();
        end
        idle_all();
        tick();
    endtask

    task automatic test_illegal_be();
        do_reset();
        drive(0, 1, 1, 32'h30, 4'b0101, 32'h12345678, 0);
        #2;
        nchk++;
        if ({rdy0, m_we, m_be} !== {2'b10, 4'b0101})
            $display("FAIL illegal_be got %b%b %b exp 10 0101", rdy0, m_we, m_be);
        else npass++;
        tick();
        drive(0, 1, 0, 32'h30, 4'b1111, '0, 0);
        tick();
        v[0] = 0;
        #2;
        nchk++;
        if ({rv0, rd0} !== {1'b1, init_word(32'h30)})
            $display("FAIL illegal_mem got %b/%h exp 1/%h", rv0, rd0, init_word(32'h30));
        else npass++;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 1, 0, 32'h70, 4'b1111, '0, 1);
        tick();
        #2;
        nchk++;
        if (rv1 !== 1'b1) $display("FAIL mid_pre got %b exp 1", rv1);
        else npass++;
        idle_all();
        rst = 1'b1;
        model_reset();
        #1;
        nchk++;
        if ({rv1, rv0, rd1} !== {2'b00, 32'h0})
            $display("FAIL mid_rst got %b/%h exp 00/0", {rv1, rv0}, rd1);
        else npass++;
        tick();
        rst = 1'b0;
        drive(0, 1, 0, 32'h71, 4'b1111, '0, 0);
        drive(1, 1, 0, 32'h72, 4'b1111, '0, 0);
        #2;
        nchk++;
        if ({rdy1, rdy0} !== 2'b01) $display("FAIL mid_lockdrop got %b exp 01", {rdy1, rdy0});
        else npass++;
        tick();
        idle_all();
        tick();
    endtask

    task automatic new_req(int p);
        logic [3:0] e;
        int r = $urandom_range(0, 9);
        e = (r == 0) ? 4'b0101 : (r < 4) ? 4'b0001 : (r < 6) ? 4'b0011 : 4'b1111;
        drive(p, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)),
              e, $urandom, $urandom_range(0, 9) < 3);
    endtask

    task automatic test_random();
        bit ovr;
        int w;
        logic [1:0]  exp_rdy;
        logic [68:0] exp_mem;
        do_reset();
        new_req(0);
        new_req(1);
        for (int c = 0; c < 400; c++) begin
            #2;
            w = pick(ovr);
            exp_rdy = (w < 0) ? 2'b00 : (w == 0) ? 2'b01 : 2'b10;
            exp_mem = (w < 0) ? '0 : {ad[w], we[w] && legal(be[w]), wd[w], be[w]};
            nchk++;
            if ({rdy1, rdy0} !== exp_rdy)
                $display("FAIL rnd_ready c%0d got %b exp %b", c, {rdy1, rdy0}, exp_rdy);
            else npass++;
            nchk++;
            if ({m_addr, m_we, m_wd, m_be} !== exp_mem)
                $display("FAIL rnd_mem c%0d got %h exp %h", c, {m_addr, m_we, m_wd, m_be}, exp_mem);
            else npass++;
            nchk++;
            if ({rv1, rv0, rd1, rd0} !== {m_rv[1], m_rv[0], m_rd[1], m_rd[0]})
                $display("FAIL rnd_rsp c%0d got %b %h %h exp %b %h %h", c, {rv1, rv0}, rd1, rd0,
                         {m_rv[1], m_rv[0]}, m_rd[1], m_rd[0]);
            else npass++;
            tick();
            for (int p = 0; p < 2; p++) if (w == p || !v[p]) new_req(p);
        end
        idle_all();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        idle_all();
        model_reset();
        test_reset();
        test_tie_after_reset();
        test_store_load();
        test_round_robin();
        test_lock();
        test_starve();
        test_illegal_be();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
